// File: rtl/round_timer.sv
// Round timer: counts a fixed-length round down in whole seconds, latches
// each player's one-hot door choice while the round runs, and holds an
// expiry flag until the processor acknowledges it.
module round_timer #(
  parameter int CLK_HZ  = 25000000,
  parameter int ROUND_S = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ack,
  input  logic [3:0] btn_j1,
  input  logic [3:0] btn_j2,
  output logic [3:0] posJ1,
  output logic [3:0] posJ2,
  output logic       time_up,
  output logic       running,
  output logic [6:0] secs_left,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones
);

  localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [6:0]      ROUND_LOAD = 7'(ROUND_S);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [6:0]      secs_q, secs_d;
  logic [3:0]      pos1_q, pos1_d;
  logic [3:0]      pos2_q, pos2_d;
  logic [3:0]      meta_j1_q, meta_j1_d;
  logic [3:0]      sync_j1_q, sync_j1_d;
  logic [3:0]      meta_j2_q, meta_j2_d;
  logic [3:0]      sync_j2_q, sync_j2_d;
  logic            wrap;
  logic            expire;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and button synchronizer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      secs_q    <= '0;
      pos1_q    <= '0;
      pos2_q    <= '0;
      meta_j1_q <= '0;
      sync_j1_q <= '0;
      meta_j2_q <= '0;
      sync_j2_q <= '0;
    end else begin
      presc_q   <= presc_d;
      secs_q    <= secs_d;
      pos1_q    <= pos1_d;
      pos2_q    <= pos2_d;
      meta_j1_q <= meta_j1_d;
      sync_j1_q <= sync_j1_d;
      meta_j2_q <= meta_j2_d;
      sync_j2_q <= sync_j2_d;
    end
  end

  // Next state plus countdown, prescaler and choice-latch updates
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    secs_d    = secs_q;
    pos1_d    = pos1_q;
    pos2_d    = pos2_q;
    meta_j1_d = btn_j1;
    sync_j1_d = meta_j1_q;
    meta_j2_d = btn_j2;
    sync_j2_d = meta_j2_q;
    wrap      = (presc_q == PRESC_MAX);
    expire    = wrap && (secs_q <= 7'd1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          presc_d = '0;
          secs_d  = ROUND_LOAD;
          pos1_d  = '0;
          pos2_d  = '0;
        end
      end
      RUN: begin
        if (start) begin
          presc_d = '0;
          secs_d  = ROUND_LOAD;
          pos1_d  = '0;
          pos2_d  = '0;
        end else if (expire) begin
          // Expiry freezes the choices: a button load on this edge is dropped
          state_d = EXPIRED;
          presc_d = '0;
          secs_d  = '0;
        end else begin
          presc_d = wrap ? '0 : presc_q + PW'(1);
          if (wrap) begin
            secs_d = secs_q - 7'd1;
          end
          if (is_onehot(sync_j1_q)) begin
            pos1_d = sync_j1_q;
          end
          if (is_onehot(sync_j2_q)) begin
            pos2_d = sync_j2_q;
          end
        end
      end
      EXPIRED: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    running = (state_q == RUN);
    time_up = (state_q == EXPIRED);
  end

  // Binary to two BCD digits; secs_left never exceeds 99
  always_comb begin
    secs_tens = '0;
    for (int unsigned i = 1; i < 10; i++) begin
      if (secs_q >= 7'(i * 10)) begin
        secs_tens = 4'(i);
      end
    end
    secs_ones = 4'(secs_q - 7'(secs_tens) * 7'd10);
  end

  assign posJ1     = pos1_q;
  assign posJ2     = pos2_q;
  assign secs_left = secs_q;

endmodule

// File: tb/tb_round_timer.sv
// Self-checking bench for round_timer with CLK_HZ=4, ROUND_S=3.
module tb_round_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ack;
  logic [3:0] btn_j1;
  logic [3:0] btn_j2;
  logic [3:0] posJ1;
  logic [3:0] posJ2;
  logic       time_up;
  logic       running;
  logic [6:0] secs_left;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         edge_n;
    logic [6:0] secs;
    logic       tu;
    logic       run;
  } cnt_exp_t;

  typedef struct {
    int         edge_n;
    logic [3:0] p1;
    logic [3:0] p2;
  } pos_exp_t;

  cnt_exp_t cq[$];
  pos_exp_t pq[$];

  round_timer #(.CLK_HZ(4), .ROUND_S(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ack       (ack),
    .btn_j1    (btn_j1),
    .btn_j2    (btn_j2),
    .posJ1     (posJ1),
    .posJ2     (posJ2),
    .time_up   (time_up),
    .running   (running),
    .secs_left (secs_left),
    .secs_tens (secs_tens),
    .secs_ones (secs_ones)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge that accepted start (edge 0)
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [6:0] model_secs(input int e);
    if (e < 4) return 7'd3;
    else if (e < 8) return 7'd2;
    else if (e < 12) return 7'd1;
    else return 7'd0;
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; ack = 1'b0; btn_j1 = '0; btn_j2 = '0;
    tick();
    tick();
    tests++; if (running !== 1'b0)  begin fails++; $display("FAIL reset_running act=%0b exp=0", running); end
    tests++; if (time_up !== 1'b0)  begin fails++; $display("FAIL reset_time_up act=%0b exp=0", time_up); end
    tests++; if (secs_left !== 7'd0) begin fails++; $display("FAIL reset_secs act=%0d exp=0", secs_left); end
    tests++; if (posJ1 !== 4'd0 || posJ2 !== 4'd0) begin fails++; $display("FAIL reset_pos act=%b/%b exp=0000/0000", posJ1, posJ2); end
    #2 reset = 1'b1;
    tick();
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL idle_after_reset act=%0b exp=0", running); end
  endtask

  task automatic test_countdown();
    cnt_exp_t x;
    for (int e = 0; e <= 12; e++) cq.push_back('{e, model_secs(e), (e == 12), (e < 12)});
    pulse_start();
    for (int e = 0; e <= 12; e++) begin
      x = cq.pop_front();
      tests++; if (secs_left !== x.secs) begin fails++; $display("FAIL cd_secs e=%0d act=%0d exp=%0d", e, secs_left, x.secs); end
      tests++; if (time_up !== x.tu) begin fails++; $display("FAIL cd_time_up e=%0d act=%0b exp=%0b", e, time_up, x.tu); end
      tests++; if (running !== x.run) begin fails++; $display("FAIL cd_running e=%0d act=%0b exp=%0b", e, running, x.run); end
      tests++; if (secs_tens !== 4'd0 || secs_ones !== 4'(x.secs)) begin fails++; $display("FAIL cd_bcd e=%0d act=%0d%0d exp=0%0d", e, secs_tens, secs_ones, x.secs); end
      if (e < 12) tick();
    end
    tests++; if (posJ1 !== 4'd0 || posJ2 !== 4'd0) begin fails++; $display("FAIL cd_pos act=%b/%b exp=0000/0000", posJ1, posJ2); end
    ack = 1'b1; tick(); ack = 1'b0;
    tests++; if (time_up !== 1'b0) begin fails++; $display("FAIL cd_ack act=%0b exp=0", time_up); end
  endtask

  task automatic test_buttons();
    pos_exp_t x;
    btn_j2 = 4'b0011;
    pulse_start();
    btn_j1 = 4'b0001;
    // pin change just after edge 0 reaches posJ on edge 3
    pq.push_back('{2, 4'b0000, 4'b0000});
    pq.push_back('{3, 4'b0001, 4'b0000});
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 5) begin
        btn_j1 = 4'b0100;
        pq.push_back('{7, 4'b0001, 4'b0000});
        pq.push_back('{8, 4'b0100, 4'b0000});
        pq.push_back('{12, 4'b0100, 4'b0000});
      end
      if (pq.size() > 0 && pq[0].edge_n == e) begin
        x = pq.pop_front();
        tests++; if (posJ1 !== x.p1) begin fails++; $display("FAIL btn_pos1 e=%0d act=%b exp=%b", e, posJ1, x.p1); end
        tests++; if (posJ2 !== x.p2) begin fails++; $display("FAIL btn_pos2 e=%0d act=%b exp=%b", e, posJ2, x.p2); end
      end
    end
    tests++; if (time_up !== 1'b1) begin fails++; $display("FAIL btn_expiry act=%0b exp=1", time_up); end
    btn_j1 = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) start = 1'b1;
      tick();
      start = 1'b0;
      tests++; if (time_up !== 1'b1 || running !== 1'b0) begin fails++; $display("FAIL hold_time_up i=%0d act=%0b/%0b exp=1/0", i, time_up, running); end
    end
    tests++; if (posJ1 !== 4'b0100) begin fails++; $display("FAIL expired_frozen act=%b exp=0100", posJ1); end
    ack = 1'b1; tick(); ack = 1'b0;
    tests++; if (time_up !== 1'b0 || running !== 1'b0) begin fails++; $display("FAIL ack_idle act=%0b/%0b exp=0/0", time_up, running); end
    btn_j1 = 4'b0001;
    repeat (5) tick();
    tests++; if (posJ1 !== 4'b0100 || secs_left !== 7'd0) begin fails++; $display("FAIL idle_hold act=%b/%0d exp=0100/0", posJ1, secs_left); end
    btn_j1 = '0; btn_j2 = '0;
  endtask

  task automatic test_back_to_back();
    btn_j1 = 4'b0010; btn_j2 = 4'b0001;
    pulse_start();
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    tests++; if (running !== 1'b1 || secs_left !== 7'd3) begin fails++; $display("FAIL ack_in_run act=%0b/%0d exp=1/3", running, secs_left); end
    repeat (10) tick();
    tests++; if (time_up !== 1'b1 || posJ1 !== 4'b0010 || posJ2 !== 4'b0001) begin fails++; $display("FAIL b2b_expiry act=%0b %b %b exp=1 0010 0001", time_up, posJ1, posJ2); end
    start = 1'b1; ack = 1'b1; tick(); start = 1'b0; ack = 1'b0;
    tests++; if (running !== 1'b0 || time_up !== 1'b0) begin fails++; $display("FAIL start_ack_same act=%0b/%0b exp=0/0", running, time_up); end
    repeat (3) tick();
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL start_dropped act=%0b exp=0", running); end
    btn_j1 = '0; btn_j2 = '0;
    pulse_start();
    tests++; if (running !== 1'b1 || posJ1 !== 4'd0 || posJ2 !== 4'd0 || secs_left !== 7'd3) begin fails++; $display("FAIL b2b_restart act=%0b %b %b %0d exp=1 0000 0000 3", running, posJ1, posJ2, secs_left); end
  endtask

  task automatic test_restart();
    cnt_exp_t x;
    pulse_start();
    repeat (5) tick();
    for (int e = 6; e <= 18; e++) cq.push_back('{e, model_secs(e - 6), (e == 18), (e < 18)});
    start = 1'b1; tick(); start = 1'b0;
    for (int e = 6; e <= 18; e++) begin
      x = cq.pop_front();
      tests++; if (secs_left !== x.secs || time_up !== x.tu || running !== x.run) begin
        fails++; $display("FAIL restart e=%0d act=%0d/%0b/%0b exp=%0d/%0b/%0b", e, secs_left, time_up, running, x.secs, x.tu, x.run);
      end
      if (e < 18) tick();
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    btn_j1 = 4'b0001; btn_j2 = 4'b1000;
    pulse_start();
    repeat (7) tick();
    tests++; if (posJ1 !== 4'b0001 || secs_left !== 7'd2) begin fails++; $display("FAIL pre_reset act=%b/%0d exp=0001/2", posJ1, secs_left); end
    reset = 1'b0;
    #1;
    tests++; if (posJ1 !== 4'd0 || posJ2 !== 4'd0 || secs_left !== 7'd0 || time_up !== 1'b0 || running !== 1'b0 || secs_tens !== 4'd0 || secs_ones !== 4'd0) begin
      fails++; $display("FAIL async_reset act=%b %b %0d %0b %0b exp=0000 0000 0 0 0", posJ1, posJ2, secs_left, time_up, running);
    end
    #1 reset = 1'b1;
    btn_j1 = '0; btn_j2 = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++; if (time_up !== 1'b0 || running !== 1'b0 || secs_tens !== 4'd0 || secs_ones !== 4'd0) begin
        fails++; $display("FAIL post_reset i=%0d act=%0b %0b %0d%0d exp=0 0 00", i, time_up, running, secs_tens, secs_ones);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_buttons();
    test_back_to_back();
    test_restart();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
